// File: rtl/circuit4_operand_loader.sv
// Operand loader: collects NUM_OPS bytes over a valid/ready stream, holds them for the
// datapath for RES_LATENCY edges, then returns the captured result. Optional: LOADER_PARITY_EN.
module circuit4_operand_loader #(
  parameter int NUM_OPS     = 16,
  parameter int OP_W        = 8,
  parameter int RES_W       = 32,
  parameter int RES_LATENCY = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [OP_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_OPS*OP_W-1:0] op_bus,
  output logic                    ops_valid,
  input  logic [RES_W-1:0]        res_in,
`ifdef LOADER_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [RES_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CNT_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int WAIT_W = $clog2(RES_LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM_OPS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RES_LATENCY - 1);

  typedef enum logic [1:0] {LOAD, EVAL, OUT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              take;
  logic              capture;

  assign take    = in_valid & in_ready;
  assign capture = (state == EVAL) && (wait_cnt == LAST_WAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_nxt  = wait_cnt;
    in_ready  = 1'b0;
    ops_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = ~Rst;
        if (take) begin
          if (cnt == LAST_SLOT) begin
            state_nxt = EVAL;
            cnt_nxt   = '0;
            wait_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      EVAL: begin
        ops_valid = 1'b1;
        // Leaves EVAL on the terminal count, so the counter never wraps.
        wait_nxt  = wait_cnt + WAIT_W'(1);
        if (capture) state_nxt = OUT;
      end
      OUT: begin
        ops_valid = 1'b1;
        if (out_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Control registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= LOAD;
      cnt       <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      if (capture)
        out_valid <= 1'b1;
      else if (state == OUT && out_ready)
        out_valid <= 1'b0;
    end
  end

  // Operand slots and result capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_bus   <= '0;
      out_data <= '0;
    end else begin
      if (take) op_bus[cnt*OP_W +: OP_W] <= in_data;
      if (capture) out_data <= res_in;
    end
  end

`ifdef LOADER_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Rst)
      out_parity <= 1'b0;
    else if (capture)
      out_parity <= ^res_in;
  end
`endif

endmodule

// File: tb/tb_circuit4_operand_loader.sv
// Directed bench for circuit4_operand_loader; res_in is modelled as the zero-extended
// sum of the 16 operand slots, expected results travel through a scoreboard queue.
module tb_circuit4_operand_loader;
  localparam int NUM_OPS = 16;
  localparam int OP_W    = 8;
  localparam int RES_W   = 32;

  logic                    Clk = 1'b0;
  logic                    Rst = 1'b1;
  logic [OP_W-1:0]         in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [NUM_OPS*OP_W-1:0] op_bus;
  logic                    ops_valid;
  logic [RES_W-1:0]        res_in;
  logic [RES_W-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
`ifdef LOADER_PARITY_EN
  logic                    out_parity;
`endif

  circuit4_operand_loader #(
    .NUM_OPS(NUM_OPS), .OP_W(OP_W), .RES_W(RES_W), .RES_LATENCY(1)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_bus(op_bus), .ops_valid(ops_valid), .res_in(res_in),
`ifdef LOADER_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    res_in = '0;
    for (int k = 0; k < NUM_OPS; k++) res_in = res_in + {24'd0, op_bus[k*OP_W +: OP_W]};
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t_first, t_last;
  logic [7:0]   bytes[NUM_OPS];
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_res;
  logic [127:0] exp_bus;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_bytes();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_OPS; i++) v[i*8 +: 8] = bytes[i];
    return v;
  endfunction

  task automatic send(input logic [7:0] b, input bit gap);
    bit done = 1'b0;
    if (gap) begin
      @(posedge Clk); #1;
    end
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge Clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) done = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
    end
    t_last = cyc;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic load_bytes(input bit gap);
    logic [31:0] s = '0;
    for (int i = 0; i < NUM_OPS; i++) s = s + {24'd0, bytes[i]};
    exp_q.push_back(s);
    exp_bus = pack_bytes();
    for (int i = 0; i < NUM_OPS; i++) begin
      send(bytes[i], gap && (i > 0));
      if (i == 0) t_first = t_last;
    end
  endtask

  // Waits for out_valid, then pops the scoreboard and checks the returned result.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      exp_res = '0;
    end else begin
      exp_res = exp_q.pop_front();
    end
    chk("out_data", out_data, exp_res);
`ifdef LOADER_PARITY_EN
    chk("out_parity", out_parity, ^exp_res);
`endif
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_op_bus", op_bus, 0);
    chk("rst_ops_valid", ops_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    Rst = 1'b0;
    #1 chk("idle_in_ready", in_ready, 1);

    // Test 1: bytes 1..16 back-to-back, out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < NUM_OPS; i++) bytes[i] = 8'(i + 1);
    load_bytes(1'b0);
    @(negedge Clk);
    chk("t1_ops_valid", ops_valid, 1);
    chk("t1_in_ready_eval", in_ready, 0);
    chk("t1_out_valid_early", out_valid, 0);
    chk("t1_op_bus", op_bus, exp_bus);
    wait_out(lat);
    chk("t1_latency", lat, 1);
    chk("t1_const", out_data, 136);
    @(negedge Clk);
    chk("t1_out_valid_drop", out_valid, 0);
    chk("t1_in_ready_back", in_ready, 1);

    // Test 2: all-ones bytes
    for (int i = 0; i < NUM_OPS; i++) bytes[i] = 8'hFF;
    load_bytes(1'b0);
    @(negedge Clk);
    chk("t2_op_bus_ones", op_bus, {128{1'b1}});
    wait_out(lat);
    chk("t2_const", out_data, 32'h0000_0FF0);
    @(negedge Clk);

    // Test 3: in_valid toggled every cycle
    for (int i = 0; i < NUM_OPS; i++) bytes[i] = 8'(i + 1);
    load_bytes(1'b1);
    chk("t3_span", t_last - t_first, 30);
    @(negedge Clk);
    chk("t3_op_bus", op_bus, exp_bus);
    wait_out(lat);
    @(negedge Clk);

    // Test 4: consumer stalls for 10 cycles; in_valid noise during OUT
    out_ready = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) bytes[i] = 8'(3 * i + 5);
    load_bytes(1'b0);
    wait_out(lat);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, exp_res);
      chk("t4_hold_bus", op_bus, exp_bus);
      chk("t4_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(negedge Clk);
    chk("t4_released", out_valid, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_bus_kept", op_bus, exp_bus);

    // Test 5: reset after 7 bytes, then bytes 10..25
    for (int i = 0; i < 7; i++) send(8'(i + 40), 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    #1 chk("t5_in_ready_rst", in_ready, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("t5_op_bus_zero", op_bus, 0);
    chk("t5_ops_valid", ops_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    for (int i = 0; i < NUM_OPS; i++) bytes[i] = 8'(i + 10);
    load_bytes(1'b0);
    wait_out(lat);
    chk("t5_const", out_data, 280);
    @(negedge Clk);

    // Test 6: all-zero bytes
    for (int i = 0; i < NUM_OPS; i++) bytes[i] = 8'h00;
    load_bytes(1'b0);
    wait_out(lat);
    chk("t6_const", out_data, 0);
    @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
